// File: rtl/cr_fifo_wr_arb_pkg.sv
// Shared types and helpers for the packet-atomic FIFO write arbiter.
//   fifo_wr_arb_state_e : arbiter FSM state (idle / locked on a packet)
//   rr_next()           : rotate-priority candidate index helper
package cr_fifo_wr_arb_pkg;

  typedef enum logic {StIdle, StLock} fifo_wr_arb_state_e;

  localparam int unsigned DefNReq      = 4;
  localparam int unsigned DefNDataBits = 64;
  localparam int unsigned DefMaxBeats  = 256;

  // Index 'step' places after 'last', wrapping at n.
  function automatic int unsigned rr_next(int unsigned last, int unsigned step, int unsigned n);
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/cr_fifo_wr_arb_if.sv
// Bundle of producer-side handshake and FIFO write-port signals.
//   req_valid/req_eop/req_data/req_ready : NReq producers, beat handshake
//   fifo_wen/fifo_wdata/fifo_src/fifo_eop: registered write port to the FIFO
//   fifo_afull/fifo_full                 : FIFO status back to the arbiter
// slave  : arbiter view; master : producers + FIFO (environment) view.
interface cr_fifo_wr_arb_if
  import cr_fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NReq      = DefNReq,
  parameter int unsigned NDataBits = DefNDataBits
);
  localparam int unsigned SrcW = (NReq > 1) ? $clog2(NReq) : 1;

  logic [NReq-1:0]           req_valid;
  logic [NReq-1:0]           req_eop;
  logic [NReq*NDataBits-1:0] req_data;
  logic [NReq-1:0]           req_ready;
  logic                      fifo_wen;
  logic [NDataBits-1:0]      fifo_wdata;
  logic [SrcW-1:0]           fifo_src;
  logic                      fifo_eop;
  logic                      fifo_afull;
  logic                      fifo_full;

  modport slave (
    input  req_valid, req_eop, req_data, fifo_afull, fifo_full,
    output req_ready, fifo_wen, fifo_wdata, fifo_src, fifo_eop
  );

  modport master (
    output req_valid, req_eop, req_data, fifo_afull, fifo_full,
    input  req_ready, fifo_wen, fifo_wdata, fifo_src, fifo_eop
  );

endinterface

// File: rtl/cr_fifo_wr_arb_rr_pick.sv
// Combinational rotate-priority picker.
//   req_i    : request vector
//   last_i   : index granted last; search starts one above it and wraps
//   onehot_o : one-hot of the chosen requester (zero when none)
//   idx_o    : index of the chosen requester
//   any_o    : at least one request present
module cr_fifo_wr_arb_rr_pick
  import cr_fifo_wr_arb_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    // Step 1..N after last; the first hit wins, so last itself has lowest priority.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdxW'(rr_next(32'(last_i), k, N));
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_fifo_wr_arb.sv
// Packet-atomic round-robin write arbiter in front of a shared FIFO.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : producer handshakes + registered FIFO write port (slave view)
//   busy        : a packet is locked
//   err_pkt_len : sticky, a packet ran past MaxBeats beats
//   err_ovf     : sticky, a write was issued while the FIFO reported full
// The grant is held from the first beat through eop. req_ready only depends on
// registered state and fifo_afull, so there is no valid->ready loop and the
// write port is one register stage behind the accept.
module cr_fifo_wr_arb
  import cr_fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NReq      = DefNReq,
  parameter int unsigned NDataBits = DefNDataBits,
  parameter int unsigned MaxBeats  = DefMaxBeats
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cr_fifo_wr_arb_if.slave         bus,
  output logic                    busy,
  output logic                    err_pkt_len,
  output logic                    err_ovf
);

  localparam int unsigned     SrcW        = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int unsigned     CntW        = $clog2(MaxBeats + 1);
  localparam logic [SrcW-1:0] LastReset   = SrcW'(NReq - 1);
  localparam logic [NReq-1:0] LastResetOh = {1'b1, {(NReq - 1){1'b0}}};
  localparam logic [CntW-1:0] CntMax      = CntW'(MaxBeats);

  fifo_wr_arb_state_e   state_q, state_d;
  logic [SrcW-1:0]      grant_q, grant_d;
  logic [NReq-1:0]      grant_oh_q, grant_oh_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 wen_q, wen_d;
  logic [NDataBits-1:0] wdata_q, wdata_d;
  logic [SrcW-1:0]      src_q, src_d;
  logic                 eop_q, eop_d;
  logic                 err_len_q, err_len_d;
  logic                 err_ovf_q, err_ovf_d;

  logic [NReq-1:0]      pick_oh;
  logic [SrcW-1:0]      pick_idx;
  logic                 pick_any;
  logic [NReq-1:0]      ready;
  logic                 accept;
  logic [NDataBits-1:0] beat_data;
  logic                 beat_eop;

  cr_fifo_wr_arb_rr_pick #(
    .N (NReq)
  ) u_pick (
    .req_i    (bus.req_valid),
    .last_i   (grant_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Beat mux driven by the registered one-hot grant.
  always_comb begin
    beat_data = '0;
    beat_eop  = 1'b0;
    for (int unsigned i = 0; i < NReq; i++) begin
      if (grant_oh_q[i]) begin
        beat_data = bus.req_data[i*NDataBits +: NDataBits];
        beat_eop  = bus.req_eop[i];
      end
    end
  end

  assign ready  = (state_q == StLock && !bus.fifo_afull) ? grant_oh_q : '0;
  assign accept = |(bus.req_valid & ready);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    cnt_d      = cnt_q;
    wen_d      = 1'b0;
    wdata_d    = wdata_q;
    src_d      = src_q;
    eop_d      = eop_q;
    err_len_d  = err_len_q;
    err_ovf_d  = err_ovf_q | (wen_q & bus.fifo_full);
    unique case (state_q)
      StIdle: begin
        if (pick_any && !bus.fifo_afull) begin
          state_d    = StLock;
          grant_d    = pick_idx;
          grant_oh_d = pick_oh;
          cnt_d      = '0;
        end
      end
      StLock: begin
        if (accept) begin
          wen_d   = 1'b1;
          wdata_d = beat_data;
          src_d   = grant_q;
          eop_d   = beat_eop;
          // Counter saturates; any beat past MaxBeats flags, packet still completes.
          if (cnt_q == CntMax) begin
            err_len_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (beat_eop) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= LastReset;
      grant_oh_q <= LastResetOh;
      cnt_q      <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      src_q      <= '0;
      eop_q      <= 1'b0;
      err_len_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      src_q      <= src_d;
      eop_q      <= eop_d;
      err_len_q  <= err_len_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.fifo_wen   = wen_q;
  assign bus.fifo_wdata = wdata_q;
  assign bus.fifo_src   = src_q;
  assign bus.fifo_eop   = eop_q;
  assign busy           = (state_q == StLock);
  assign err_pkt_len    = err_len_q;
  assign err_ovf        = err_ovf_q;

endmodule

// File: tb/tb_cr_fifo_wr_arb.sv
// Bench for cr_fifo_wr_arb: directed scenarios plus a random phase, all checked
// every cycle against a packet-level reference model of the arbiter.
module tb_cr_fifo_wr_arb;

  localparam int NR  = 4;
  localparam int DW  = 64;
  localparam int MB  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, err_pkt_len, err_ovf;

  always #5 clk = ~clk;

  cr_fifo_wr_arb_if #(.NReq(NR), .NDataBits(DW)) bus ();

  cr_fifo_wr_arb #(
    .NReq      (NR),
    .NDataBits (DW),
    .MaxBeats  (MB)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .err_pkt_len (err_pkt_len),
    .err_ovf     (err_ovf)
  );

  int total, bad;

  // Producers: each owns a current beat and the beats left in its packet.
  bit          en[NR];
  int          pv[NR];
  int          fixed_len[NR];
  int          rem[NR];
  logic [63:0] sdata[NR];

  // Reference model: owner of the locked packet (-1 none), last winner, beats in
  // the current packet, and the write the FIFO should see this cycle.
  int          m_owner, m_last, m_beats, m_src;
  bit          m_wen, m_eop, m_errlen, m_errovf;
  logic [63:0] m_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic new_len(input int k);
    rem[k] = (fixed_len[k] > 0) ? fixed_len[k] : int'($urandom_range(1, 10));
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = NR - 1; m_beats = 0; m_src = 0;
    m_wen = 0; m_eop = 0; m_errlen = 0; m_errovf = 0; m_wdata = '0;
    for (int k = 0; k < NR; k++) begin
      new_len(k);
      sdata[k] = {$urandom, $urandom};
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      bus.req_valid[k]           = en[k] && ($urandom_range(0, 99) < pv[k]);
      bus.req_eop[k]             = (rem[k] == 1);
      bus.req_data[k*DW +: DW]   = sdata[k];
    end
  endtask

  // One clock: drive, check at the falling edge, advance the model at the rise.
  task automatic cycle();
    logic [NR-1:0] exp_rdy, vld;
    bit            afull, ovf_now;
    int            acc;
    drive();
    @(negedge clk);
    exp_rdy = '0;
    if (m_owner >= 0 && !bus.fifo_afull) exp_rdy[m_owner] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("fifo_wen", 64'(bus.fifo_wen), 64'(m_wen));
    if (m_wen) begin
      check("fifo_wdata", bus.fifo_wdata, m_wdata);
      check("fifo_src", 64'(bus.fifo_src), 64'(m_src));
      check("fifo_eop", 64'(bus.fifo_eop), 64'(m_eop));
    end
    check("busy", 64'(busy), 64'(m_owner >= 0));
    check("err_pkt_len", 64'(err_pkt_len), 64'(m_errlen));
    check("err_ovf", 64'(err_ovf), 64'(m_errovf));
    vld   = bus.req_valid;
    afull = bus.fifo_afull;
    acc   = (m_owner >= 0 && vld[m_owner] && !afull) ? m_owner : -1;
    ovf_now = m_wen && bus.fifo_full;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_wen = 0;
      if (acc >= 0) begin
        m_wen   = 1;
        m_wdata = sdata[acc];
        m_src   = acc;
        m_eop   = (rem[acc] == 1);
        m_beats++;
        if (m_beats > MB) m_errlen = 1;
        if (m_eop) m_owner = -1;
        sdata[acc] = {$urandom, $urandom};
        rem[acc]--;
        if (rem[acc] == 0) new_len(acc);
      end else if (m_owner < 0 && vld != '0 && !afull) begin
        for (int k = 1; k <= NR; k++) begin
          if (m_owner < 0 && vld[(m_last + k) % NR]) m_owner = (m_last + k) % NR;
        end
        m_last  = m_owner;
        m_beats = 0;
      end
      if (ovf_now) m_errovf = 1;
    end
    #1;
  endtask

  // Let the packet in flight finish, with every other producer idle.
  task automatic drain();
    int n = 0;
    for (int k = 0; k < NR; k++) begin
      en[k] = (k == m_owner);
      pv[k] = 100;
    end
    bus.fifo_afull = 1'b0;
    bus.fifo_full  = 1'b0;
    while (m_owner >= 0 && n < 100) begin
      cycle();
      n++;
    end
    check("drain_busy", 64'(busy), 64'(0));
    for (int k = 0; k < NR; k++) begin
      fixed_len[k] = 0;
      en[k]        = 1'b0;
    end
  endtask

  task automatic restart_sources();
    for (int k = 0; k < NR; k++) new_len(k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcnt;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid  = '0;
    bus.req_eop    = '0;
    bus.req_data   = '0;
    bus.fifo_afull = 1'b0;
    bus.fifo_full  = 1'b0;
    for (int k = 0; k < NR; k++) begin
      en[k] = 0; pv[k] = 100; fixed_len[k] = 0;
    end
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check("rst_wen", 64'(bus.fifo_wen), 64'(0));
    check("rst_wdata", bus.fifo_wdata, 64'(0));
    check("rst_src", 64'(bus.fifo_src), 64'(0));
    check("rst_eop", 64'(bus.fifo_eop), 64'(0));
    check("rst_ready", 64'(bus.req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_errs", 64'({err_pkt_len, err_ovf}), 64'(0));
    rst_n = 1'b1;

    // 1: all four request 1-beat packets -> grants 0,1,2,3, a write every 2nd cycle.
    for (int k = 0; k < NR; k++) begin
      en[k] = 1; fixed_len[k] = 1;
    end
    restart_sources();
    wcnt = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (bus.fifo_wen) begin
        check("t1_src_order", 64'(bus.fifo_src), 64'(wcnt));
        wcnt++;
      end
    end
    check("t1_write_count", 64'(wcnt), 64'(4));

    // 2: req0 4-beat packet while req1 waits -> 0,0,0,0 then 1.
    drain();
    en[0] = 1; fixed_len[0] = 4;
    en[1] = 1; fixed_len[1] = 1;
    restart_sources();
    wcnt = 0;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (bus.fifo_wen && wcnt < 5) begin
        check("t2_src", 64'(bus.fifo_src), 64'((wcnt < 4) ? 0 : 1));
        check("t2_eop", 64'(bus.fifo_eop), 64'(wcnt >= 3));
        wcnt++;
      end
    end
    check("t2_writes_seen", 64'(wcnt), 64'(5));

    // 3: afull in idle blocks arbitration; afull mid-packet stalls accepts.
    drain();
    en[1] = 1; fixed_len[1] = 6;
    restart_sources();
    bus.fifo_afull = 1'b1;
    repeat (3) cycle();
    check("t3_idle_busy", 64'(busy), 64'(0));
    bus.fifo_afull = 1'b0;
    repeat (3) cycle();
    bus.fifo_afull = 1'b1;
    repeat (3) cycle();
    check("t3_stall_busy", 64'(busy), 64'(1));
    bus.fifo_afull = 1'b0;
    repeat (8) cycle();

    // 4: req2 drops valid for 5 cycles mid-packet; grant held, others stalled.
    drain();
    for (int k = 0; k < NR; k++) begin
      en[k] = 1; fixed_len[k] = 2;
    end
    fixed_len[2] = 6;
    restart_sources();
    repeat (3) cycle();
    pv[2] = 0;
    repeat (5) cycle();
    check("t4_hold_busy", 64'(busy), 64'(1));
    pv[2] = 100;
    repeat (8) cycle();

    // 5: over-long packet on req3, then a normal packet from req0.
    drain();
    en[3] = 1; fixed_len[3] = MB + 1;
    restart_sources();
    repeat (12) cycle();
    check("t5_err_pkt_len", 64'(err_pkt_len), 64'(1));
    drain();
    en[0] = 1; fixed_len[0] = 2;
    restart_sources();
    repeat (6) cycle();

    // 6: reset mid-packet, first grant to req0; then write into a full FIFO.
    drain();
    for (int k = 0; k < NR; k++) begin
      en[k] = 1; fixed_len[k] = 4;
    end
    restart_sources();
    repeat (8) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("t6_post_rst_busy", 64'(busy), 64'(0));
    check("t6_post_rst_err", 64'(err_pkt_len), 64'(0));
    cycle();
    cycle();
    check("t6_first_wen", 64'(bus.fifo_wen), 64'(1));
    check("t6_first_src", 64'(bus.fifo_src), 64'(0));
    bus.fifo_full = 1'b1;
    repeat (4) cycle();
    bus.fifo_full = 1'b0;
    check("t6_err_ovf", 64'(err_ovf), 64'(1));

    // Random traffic against the model.
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        for (int k = 0; k < NR; k++) begin
          en[k] = 1; fixed_len[k] = 0; pv[k] = int'($urandom_range(20, 100));
        end
      end
      bus.fifo_afull = ($urandom_range(0, 99) < 15);
      bus.fifo_full  = ($urandom_range(0, 99) < 3);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
